// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the word-wide data-memory interface. Accepts RV32I
//   load/store requests from the core, issues word-aligned mem_read /
//   mem_write accesses and waits for mem_ready. Memory has no byte enables,
//   so SB/SH run as read-modify-write. Load data is sign/zero-extended.
//   Misaligned or illegal requests and memory timeouts are flagged.
//
//   state | meaning
//   IDLE  | waiting for lsu_valid; request latched on accept
//   RD    | mem_read high, waiting for mem_ready (load, or SB/SH read phase)
//   WR    | mem_write high, waiting for mem_ready (SW, or SB/SH write phase)
//   DONE  | lsu_done pulse for one cycle, then back to IDLE
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   lsu_valid/is_store/funct3/addr/wdata   request from the core
//   lsu_busy, lsu_done     status; done is a one-cycle pulse
//   lsu_rdata              extended load result, held until overwritten
//   lsu_misaligned/timeout sticky error flags, cleared on the next accept
//   mem_read/write/addr/wdata, mem_rdata, mem_ready   data-memory side
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic        lsu_is_store,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misaligned,
  output logic        lsu_timeout,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  // Wait timer is a down-counter loaded on entry to RD/WR; reaching zero
  // without mem_ready means TIMEOUT cycles have gone by unanswered.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [2:0]    f3_q, f3_d;
  logic          st_q, st_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_addr_d, mem_wdata_d, rdata_d;
  logic          mis_d, to_d;

  logic          req_illegal, expired;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_ext, merged;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      lane_q         <= '0;
      f3_q           <= '0;
      st_q           <= 1'b0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      lsu_rdata      <= '0;
      lsu_misaligned <= 1'b0;
      lsu_timeout    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lane_q         <= lane_d;
      f3_q           <= f3_d;
      st_q           <= st_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
      lsu_rdata      <= rdata_d;
      lsu_misaligned <= mis_d;
      lsu_timeout    <= to_d;
    end
  end

  assign lsu_busy  = (state_q != IDLE);
  assign lsu_done  = (state_q == DONE);
  assign mem_read  = (state_q == RD);
  assign mem_write = (state_q == WR);

  always_comb begin
    req_illegal = 1'b0;
    if (lsu_is_store && lsu_funct3 > 3'd2)
      req_illegal = 1'b1;
    if (!lsu_is_store && (lsu_funct3 == 3'd3 || lsu_funct3 == 3'd6 || lsu_funct3 == 3'd7))
      req_illegal = 1'b1;
    if (lsu_funct3[1:0] == 2'd1 && lsu_addr[0])
      req_illegal = 1'b1;
    if (lsu_funct3[1:0] == 2'd2 && lsu_addr[1:0] != 2'd0)
      req_illegal = 1'b1;
  end

  assign expired = TO_EN && (cnt_q == '0);

  // Little-endian lane selection and sub-word merge for read-modify-write.
  always_comb begin
    rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    rd_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'd0:    load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    load_ext = {{16{rd_half[15]}}, rd_half};
      3'd4:    load_ext = {24'h0, rd_byte};
      3'd5:    load_ext = {16'h0, rd_half};
      default: load_ext = mem_rdata;
    endcase
    merged = mem_rdata;
    if (f3_q[0])
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    else
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    f3_d        = f3_q;
    st_d        = st_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rdata_d     = lsu_rdata;
    mis_d       = lsu_misaligned;
    to_d        = lsu_timeout;
    case (state_q)
      IDLE: begin
        if (lsu_valid) begin
          lane_d     = lsu_addr[1:0];
          f3_d       = lsu_funct3;
          st_d       = lsu_is_store;
          wdata_d    = lsu_wdata[15:0];
          mem_addr_d = {lsu_addr[31:2], 2'b00};
          cnt_d      = CNT_LOAD;
          mis_d      = 1'b0;
          to_d       = 1'b0;
          if (req_illegal) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else if (lsu_is_store && lsu_funct3 == 3'd2) begin
            mem_wdata_d = lsu_wdata;
            state_d     = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (mem_ready) begin
          if (st_q) begin
            mem_wdata_d = merged;
            cnt_d       = CNT_LOAD;
            state_d     = WR;
          end else begin
            rdata_d = load_ext;
            state_d = DONE;
          end
        end else if (expired) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WR: begin
        if (mem_ready) begin
          state_d = DONE;
        end else if (expired) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
